serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..16).
REQ-002 The module SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit, request to begin an operation; sampled only in IDLE or DONE.
REQ-005 The module SHALL have port sub, input, 1 bit, operation select (0 = A+B, 1 = A-B); sampled with start.
REQ-006 The module SHALL have ports a and b, input, WIDTH bits each, two's-complement operands; sampled with start.
REQ-007 The module SHALL have port busy, output, 1 bit, high while in SHIFT.
REQ-008 The module SHALL have port done, output, 1 bit, one-cycle pulse marking valid result.
REQ-009 The module SHALL have port r, output, WIDTH bits, result register.
REQ-010 The module SHALL have port cout, output, 1 bit, final carry out of the MSB stage.
REQ-011 The module SHALL have ports op_s, sgn_a, sgn_b, sgn_r, output, 1 bit each, operation select and sign bits of a, b and r; these drive the downstream overflow detector.
REQ-012 The module SHALL have port ovf_in, input, 1 bit, overflow indication returned by the downstream overflow detector.
REQ-013 The module SHALL have port ovf_flag, output, 1 bit, registered overflow status of the last completed operation.

Function
REQ-014 The FSM SHALL have three states, IDLE, SHIFT and DONE; IDLE->SHIFT on start, SHIFT->DONE after WIDTH bit-cycles, DONE->SHIFT on start, DONE->IDLE otherwise.
REQ-015 On acceptance of start, the block SHALL load A, load B (inverted when sub=1), set carry=sub, clear the bit counter, latch op_s, sgn_a=a[WIDTH-1] and sgn_b=b[WIDTH-1] (b uninverted), and clear ovf_flag.
REQ-016 Each SHIFT cycle SHALL add A[0], B[0] and carry, shift the sum bit into r from the MSB side, shift A and B right by one, and update carry.
REQ-017 done SHALL be high for exactly one cycle, starting WIDTH+1 rising edges after the edge that accepts start; r, cout and sgn_r=r[WIDTH-1] SHALL be valid from that cycle.
REQ-018 r, cout, op_s, sgn_a, sgn_b and sgn_r SHALL hold their values until the next start is accepted.
REQ-019 ovf_flag SHALL capture ovf_in at the edge that ends the DONE cycle and hold it until the next start is accepted or reset.
REQ-020 start SHALL be ignored while busy=1; operands presented then SHALL NOT alter the operation in progress.
REQ-021 start in the DONE cycle SHALL be accepted, giving back-to-back operations with no IDLE cycle; ovf_flag SHALL still capture ovf_in for the completing operation before clearing is visible in the following cycle.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; cout SHALL be the carry of A + ~B + 1 for subtraction.

Reset
REQ-023 With reset=1 at a clock edge, the FSM SHALL enter IDLE and busy, done, r, cout, op_s, sgn_a, sgn_b, sgn_r and ovf_flag SHALL become 0, including mid-operation.
REQ-024 start sampled in the same cycle as reset=1 SHALL be ignored.

Structure
REQ-025 The FSM state encoding and the default WIDTH SHALL live in the shared package lsd_pkg.
REQ-026 The per-bit sum and carry logic SHALL be a sub-module named full_adder, instantiated once.

Verification
REQ-027 a=100, b=27, sub=0 -> done 9 cycles after start, r=127, cout=0, sgn_r=0, ovf_flag=0.
REQ-028 a=100, b=28, sub=0 -> r=0x80, sgn_a=0, sgn_b=0, sgn_r=1, ovf_flag=1 one cycle after done.
REQ-029 a=0x80, b=0x01, sub=1 -> r=0x7F, cout=1, ovf_flag=1.
REQ-030 start pulsed again 3 cycles after acceptance with different operands -> ignored, first result unchanged, a single done pulse.
REQ-031 reset asserted during the 4th SHIFT cycle -> next cycle IDLE, all outputs 0, no done pulse.
REQ-032 start held high through DONE with a second operand pair (5-3, sub=1) -> first result reported, r=2 after a further 9 cycles, ovf_flag=0.

Source files
------------

// File: rtl/lsd_pkg.sv
// Shared definitions for the serial add/subtract block.
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : FSM state encoding used by serial_addsub
//   cnt_bits()    : width of a counter able to hold the value 0..width
package lsd_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic int cnt_bits(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used as the per-bit stage of the serial adder.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   co   : carry out
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, LSB first, one bit per clock.
//   clk, reset      : clock, synchronous active-high reset
//   start, sub, a, b: operation request, select (1 = a-b) and operands
//   busy, done      : SHIFT in progress / one-cycle result-valid pulse
//   r, cout         : result and final carry out of the MSB stage
//   op_s, sgn_a/b/r : operation and sign bits for the external overflow detector
//   ovf_in          : overflow returned by that detector
//   ovf_flag        : registered overflow of the last completed operation
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_SHIFT | WIDTH bit cycles followed by one settle cycle (busy=1)
// ST_DONE  | result valid, done=1; start here chains the next operation
module serial_addsub
   import lsd_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] r,
   output logic             cout,
   output logic             op_s,
   output logic             sgn_a,
   output logic             sgn_b,
   output logic             sgn_r,
   input  logic             ovf_in,
   output logic             ovf_flag
);

   localparam int            CW   = cnt_bits(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             sum_bit;
   logic             carry_nx;
   logic             accept;
   logic             bit_cyc;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      accept   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            busy = 1'b1;
            if (cnt == LAST) state_nx = ST_DONE;
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               accept   = 1'b1;
               state_nx = ST_SHIFT;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // The counter stops at WIDTH; the cycle spent there is the settle cycle.
   assign bit_cyc = busy && (cnt != LAST);

   full_adder u_fa (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .cin (carry),
      .s   (sum_bit),
      .co  (carry_nx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sh     <= '0;
         b_sh     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         r        <= '0;
         op_s     <= 1'b0;
         sgn_a    <= 1'b0;
         sgn_b    <= 1'b0;
         ovf_flag <= 1'b0;
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= sub ? ~b : b;
         carry <= sub;
         cnt   <= '0;
         op_s  <= sub;
         sgn_a <= a[WIDTH-1];
         sgn_b <= b[WIDTH-1];
         // A chained start still records the completing operation's overflow;
         // the clear lands on the first bit cycle of the new operation.
         ovf_flag <= (state == ST_DONE) ? ovf_in : 1'b0;
      end else if (bit_cyc) begin
         r     <= {sum_bit, r[WIDTH-1:1]};
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         carry <= carry_nx;
         cnt   <= cnt + 1'b1;
         if (cnt == '0) ovf_flag <= 1'b0;
      end else if (state == ST_DONE) begin
         ovf_flag <= ovf_in;
      end
   end

   assign cout  = carry;
   assign sgn_r = r[WIDTH-1];

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] r;
   logic         cout;
   logic         op_s;
   logic         sgn_a;
   logic         sgn_b;
   logic         sgn_r;
   logic         ovf_in;
   logic         ovf_flag;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Stand-in for the downstream overflow detector.
   assign ovf_in = op_s ? ((sgn_a != sgn_b) && (sgn_r != sgn_a))
                        : ((sgn_a == sgn_b) && (sgn_r != sgn_a));

   serial_addsub #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .r        (r),
      .cout     (cout),
      .op_s     (op_s),
      .sgn_a    (sgn_a),
      .sgn_b    (sgn_b),
      .sgn_r    (sgn_r),
      .ovf_in   (ovf_in),
      .ovf_flag (ovf_flag)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: signed integer arithmetic, wrapped to W bits.
   task automatic model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                        output logic [W-1:0] er, output logic ec, output logic eo);
      int         sa, sb, s;
      logic [W:0] full;
      sa   = $signed(xa);
      sb   = $signed(xb);
      s    = xs ? sa - sb : sa + sb;
      full = xs ? ({1'b0, xa} + {1'b0, ~xb} + (W+1)'(1)) : ({1'b0, xa} + {1'b0, xb});
      er   = W'(s);
      ec   = full[W];
      eo   = (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts an operation (state must be IDLE or DONE) and checks the full
   // timeline. poke>0 re-pulses start with other operands before edge poke.
   // chain=1 leaves start high with the next operands during the DONE cycle.
   task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                         input int poke, input bit chain,
                         input logic [W-1:0] na, input logic [W-1:0] nb, input logic ns);
      logic [W-1:0] er;
      logic         ec, eo;
      model(xa, xb, xs, er, ec, eo);
      start = 1'b1; a = xa; b = xb; sub = xs;
      step();
      start = 1'b0; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      check("busy_after_accept", busy, 1);
      check("op_s_latched", op_s, xs);
      for (int i = 1; i <= W; i++) begin
         if (i == poke) begin
            start = 1'b1; a = ~xa; b = xb ^ 8'h5A; sub = ~xs;
         end else begin
            start = 1'b0;
         end
         step();
         check("busy_shift", busy, 1);
         check("done_early", done, 0);
         if (i == 1) check("ovf_cleared", ovf_flag, 0);
      end
      start = 1'b0;
      step();
      check("done_pulse", done, 1);
      check("busy_in_done", busy, 0);
      check("r", r, er);
      check("cout", cout, ec);
      check("sgn_r", sgn_r, er[W-1]);
      check("sgn_a", sgn_a, xa[W-1]);
      check("sgn_b", sgn_b, xb[W-1]);
      check("op_s", op_s, xs);
      if (chain) begin
         start = 1'b1; a = na; b = nb; sub = ns;
      end else begin
         step();
         check("done_single", done, 0);
         check("ovf_flag", ovf_flag, eo);
         check("r_hold", r, er);
         check("cout_hold", cout, ec);
      end
   endtask

   initial begin
      logic [W-1:0] ca, cb, xa, xb;
      logic         cs, xs;
      bit           ch;

      reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      step();
      step();
      check("reset_outputs", {busy, done, r, cout, op_s, sgn_a, sgn_b, sgn_r, ovf_flag}, 0);
      reset = 1'b0;
      step();
      check("idle_busy", busy, 0);

      // Directed cases.
      run_op(8'd100, 8'd27, 1'b0, 0, 1'b0, '0, '0, 1'b0);
      check("r_127", r, 127);
      run_op(8'd100, 8'd28, 1'b0, 0, 1'b0, '0, '0, 1'b0);
      check("ovf_100_28", ovf_flag, 1);
      run_op(8'h80, 8'h01, 1'b1, 0, 1'b0, '0, '0, 1'b0);
      check("ovf_80_01", ovf_flag, 1);
      check("cout_80_01", cout, 1);
      run_op(8'h12, 8'h34, 1'b0, 4, 1'b0, '0, '0, 1'b0);
      run_op(8'd9, 8'd4, 1'b0, 0, 1'b1, 8'd5, 8'd3, 1'b1);
      run_op(8'd5, 8'd3, 1'b1, 0, 1'b0, '0, '0, 1'b0);
      check("r_5_minus_3", r, 2);
      check("ovf_5_minus_3", ovf_flag, 0);

      // Reset in the 4th SHIFT cycle.
      start = 1'b1; a = 8'hFF; b = 8'h00; sub = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midop_reset_outputs", {busy, done, r, cout, op_s, sgn_a, sgn_b, sgn_r, ovf_flag}, 0);
      for (int i = 0; i < W + 3; i++) begin
         step();
         check("no_done_after_reset", {busy, done}, 0);
      end

      // start together with reset is ignored.
      run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, '0, '0, 1'b0);
      reset = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22;
      step();
      reset = 1'b0; start = 1'b0;
      check("reset_start_outputs", {busy, done, r, cout, op_s, sgn_a, sgn_b, sgn_r, ovf_flag}, 0);
      step();
      check("reset_start_ignored", busy, 0);

      // Random operations, some chained back to back.
      ca = W'($urandom); cb = W'($urandom); cs = 1'($urandom);
      for (int n = 0; n < 24; n++) begin
         xa = W'($urandom); xb = W'($urandom); xs = 1'($urandom);
         ch = (n != 23) && ($urandom_range(0, 2) == 0);
         run_op(ca, cb, cs, (n % 5 == 0) ? 3 : 0, ch, xa, xb, xs);
         ca = xa; cb = xb; cs = xs;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
